// File: rtl/expr_chk_pkg.sv
// rtl/expr_chk_pkg.sv - shared constants, field layout and FSM states for expr_result_checker
// Contents:
//   Y_W, NUM_FIELDS        packed result bus width and field count
//   FIELD_W, FIELD_LSB     per-field width and LSB position, index 0 = y0 (MSB end)
//   DEF_MISR_SEED/POLY     default signature seed and feedback polynomial
//   state_t                checker run state
//   misr_fold              folds the 90-bit result into 32 bits for the MISR
package expr_chk_pkg;

  localparam int Y_W        = 90;
  localparam int NUM_FIELDS = 18;

  localparam int FIELD_W [NUM_FIELDS] = '{
    4, 5, 6, 4, 5, 6, 4, 5, 6, 4, 5, 6, 4, 5, 6, 4, 5, 6
  };

  localparam int FIELD_LSB [NUM_FIELDS] = '{
    86, 81, 75, 71, 66, 60, 56, 51, 45, 41, 36, 30, 26, 21, 15, 11, 6, 0
  };

  localparam logic [31:0] DEF_MISR_SEED = 32'hFFFF_FFFF;
  localparam logic [31:0] DEF_MISR_POLY = 32'h04C1_1DB7;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  function automatic logic [31:0] misr_fold(input logic [Y_W-1:0] y);
    return y[31:0] ^ y[63:32] ^ {6'b0, y[89:64]};
  endfunction

endpackage

// File: rtl/expr_result_checker_if.sv
// rtl/expr_result_checker_if.sv - result beat handshake between result source and checker
// Signals:
//   in_valid   source -> checker  dut_y/ref_y beat valid
//   in_ready   checker -> source  beat accepted when in_valid & in_ready
//   dut_y      source -> checker  {y0..y17} from the device under test
//   ref_y      source -> checker  {y0..y17} from the golden model
// Modports: master = result source, slave = checker.
interface expr_result_checker_if;
  import expr_chk_pkg::*;

  logic           in_valid;
  logic           in_ready;
  logic [Y_W-1:0] dut_y;
  logic [Y_W-1:0] ref_y;

  modport master (
    output in_valid,
    output dut_y,
    output ref_y,
    input  in_ready
  );

  modport slave (
    input  in_valid,
    input  dut_y,
    input  ref_y,
    output in_ready
  );

endinterface

// File: rtl/expr_misr32.sv
// rtl/expr_misr32.sv - 32-bit MISR compacting folded result beats into a signature
// Ports:
//   clk, rst    clock, asynchronous active-high reset (loads SEED)
//   load_seed   synchronous reload of SEED, wins over enable
//   enable      absorb y into the signature this cycle
//   y           packed result beat
//   sig         current signature
module expr_misr32
  import expr_chk_pkg::*;
#(
  parameter logic [31:0] SEED = DEF_MISR_SEED,
  parameter logic [31:0] POLY = DEF_MISR_POLY
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           load_seed,
  input  logic           enable,
  input  logic [Y_W-1:0] y,
  output logic [31:0]    sig
);

  logic [31:0] fold;
  logic [31:0] sig_step;

  assign fold     = misr_fold(y);
  // Galois-style shift with polynomial feedback, then XOR in the folded beat.
  assign sig_step = {sig[30:0], 1'b0} ^ (sig[31] ? POLY : 32'h0) ^ fold;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sig <= SEED;
    end else if (load_seed) begin
      sig <= SEED;
    end else if (enable) begin
      sig <= sig_step;
    end
  end

endmodule

// File: rtl/expr_result_checker.sv
// rtl/expr_result_checker.sv - compares DUT result beats against golden results, counts errors, signs results
// Ports:
//   clk, rst           clock, asynchronous active-high reset
//   start              1-cycle pulse: clear stats and begin a run (ignored while running)
//   num_vec            beats per run, sampled on start
//   bus                slave side of the result beat handshake
//   busy               run in progress
//   done               run complete, held until next start
//   pass               done with no failing vectors
//   err_cnt            vectors with at least one mismatching field, saturating
//   first_err_idx      0-based beat index of the first failing vector
//   first_err_fields   field mismatch vector of first failure, bit17 = y0 ... bit0 = y17
//   signature          MISR over every accepted dut_y
module expr_result_checker
  import expr_chk_pkg::*;
#(
  parameter int          CNT_W     = 16,
  parameter logic [31:0] MISR_SEED = DEF_MISR_SEED,
  parameter logic [31:0] MISR_POLY = DEF_MISR_POLY
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [CNT_W-1:0]      num_vec,
  expr_result_checker_if.slave  bus,
  output logic                  busy,
  output logic                  done,
  output logic                  pass,
  output logic [CNT_W-1:0]      err_cnt,
  output logic [CNT_W-1:0]      first_err_idx,
  output logic [NUM_FIELDS-1:0] first_err_fields,
  output logic [31:0]           signature
);

  state_t                state;
  state_t                state_nxt;
  logic [CNT_W-1:0]      num_vec_q;
  logic [CNT_W-1:0]      vec_idx;
  logic [NUM_FIELDS-1:0] mismatch;
  logic                  start_ok;
  logic                  accept;
  logic                  last_beat;
  logic                  any_err;

  assign start_ok  = start && (state != RUN);
  assign accept    = bus.in_valid && (state == RUN);
  // num_vec_q is never zero in RUN, so the subtraction cannot wrap here.
  assign last_beat = (vec_idx == num_vec_q - CNT_W'(1));
  assign any_err   = |mismatch;

  assign bus.in_ready = (state == RUN);
  assign pass         = done && (err_cnt == '0);

  // Field g is y<g>; its result lands at bit NUM_FIELDS-1-g so y0 is the MSB.
  for (genvar g = 0; g < NUM_FIELDS; g++) begin : g_field
    localparam int W = FIELD_W[g];
    localparam int L = FIELD_LSB[g];
    assign mismatch[NUM_FIELDS-1-g] = (bus.dut_y[L +: W] != bus.ref_y[L +: W]);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, DONE: begin
        if (start) begin
          state_nxt = (num_vec != '0) ? RUN : DONE;
        end
      end
      RUN: begin
        if (accept && last_beat) begin
          state_nxt = DONE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      busy <= (state_nxt == RUN);
      done <= (state_nxt == DONE);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      num_vec_q        <= '0;
      vec_idx          <= '0;
      err_cnt          <= '0;
      first_err_idx    <= '0;
      first_err_fields <= '0;
    end else if (start_ok) begin
      num_vec_q        <= num_vec;
      vec_idx          <= '0;
      err_cnt          <= '0;
      first_err_idx    <= '0;
      first_err_fields <= '0;
    end else if (accept) begin
      vec_idx <= vec_idx + CNT_W'(1);
      if (any_err) begin
        if (err_cnt != '1) begin
          err_cnt <= err_cnt + CNT_W'(1);
        end
        // err_cnt saturates and never returns to zero, so zero marks "no failure yet".
        if (err_cnt == '0) begin
          first_err_idx    <= vec_idx;
          first_err_fields <= mismatch;
        end
      end
    end
  end

  expr_misr32 #(
    .SEED (MISR_SEED),
    .POLY (MISR_POLY)
  ) u_misr (
    .clk       (clk),
    .rst       (rst),
    .load_seed (start_ok),
    .enable    (accept),
    .y         (bus.dut_y),
    .sig       (signature)
  );

endmodule

// File: tb/tb_expr_result_checker.sv
// tb/tb_expr_result_checker.sv - self-checking bench for expr_result_checker
module tb_expr_result_checker;

  localparam int          CNT_W = 16;
  localparam logic [31:0] SEED  = 32'hFFFF_FFFF;
  localparam logic [31:0] POLY  = 32'h04C1_1DB7;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic [CNT_W-1:0] num_vec;
  logic             busy;
  logic             done;
  logic             pass;
  logic [CNT_W-1:0] err_cnt;
  logic [CNT_W-1:0] first_err_idx;
  logic [17:0]      first_err_fields;
  logic [31:0]      signature;

  expr_result_checker_if bus();

  expr_result_checker #(.CNT_W(CNT_W)) dut (
    .clk              (clk),
    .rst              (rst),
    .start            (start),
    .num_vec          (num_vec),
    .bus              (bus),
    .busy             (busy),
    .done             (done),
    .pass             (pass),
    .err_cnt          (err_cnt),
    .first_err_idx    (first_err_idx),
    .first_err_fields (first_err_fields),
    .signature        (signature)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: beats accepted in the current run, plus run bookkeeping.
  logic [89:0] m_dut[$];
  logic [89:0] m_ref[$];
  int          m_nv;
  logic        m_run;

  typedef struct {
    int          nv;
    int          fb1;
    int          bit1;
    int          fb2;
    int          bit2;
    logic [15:0] e_err;
    logic [15:0] e_idx;
    logic [17:0] e_fields;
    logic        e_pass;
  } vec_t;

  vec_t        tbl[7];
  logic [89:0] d;
  logic [89:0] r;
  logic        v;
  logic        acc;
  int          acc_cnt;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [89:0] rand90();
    logic [95:0] t;
    t = {$urandom, $urandom, $urandom};
    return t[89:0];
  endfunction

  // Field widths cycle 4,5,6 from the MSB end; result bit 17 is y0.
  function automatic logic [17:0] field_diff(input logic [89:0] a, input logic [89:0] c);
    logic [17:0] res;
    int          top;
    int          w;
    res = '0;
    top = 90;
    for (int f = 0; f < 18; f++) begin
      w = 4 + (f % 3);
      for (int k = top - w; k < top; k++) begin
        if (a[k] != c[k]) res[17-f] = 1'b1;
      end
      top -= w;
    end
    return res;
  endfunction

  function automatic logic [31:0] misr_next(input logic [31:0] s, input logic [89:0] y);
    logic [31:0] f;
    logic [31:0] n;
    f = y[31:0] ^ y[63:32] ^ {6'b0, y[89:64]};
    n = s << 1;
    if (s[31]) n = n ^ POLY;
    return n ^ f;
  endfunction

  task automatic m_accept(input logic [89:0] dv, input logic [89:0] rv);
    m_dut.push_back(dv);
    m_ref.push_back(rv);
    if (m_dut.size() == m_nv) m_run = 1'b0;
  endtask

  task automatic check_stats(input string tag);
    int          errs;
    logic [15:0] fidx;
    logic [17:0] ff;
    logic [31:0] sig;
    logic [17:0] dv;
    errs = 0;
    fidx = '0;
    ff   = '0;
    sig  = SEED;
    for (int i = 0; i < m_dut.size(); i++) begin
      dv = field_diff(m_dut[i], m_ref[i]);
      if (dv != '0) begin
        if (errs == 0) begin
          fidx = 16'(i);
          ff   = dv;
        end
        errs++;
      end
      sig = misr_next(sig, m_dut[i]);
    end
    check({tag, ".done"}, done, 1);
    check({tag, ".busy"}, busy, 0);
    check({tag, ".err_cnt"}, err_cnt, errs);
    check({tag, ".first_err_idx"}, first_err_idx, fidx);
    check({tag, ".first_err_fields"}, first_err_fields, ff);
    check({tag, ".pass"}, pass, errs == 0);
    check({tag, ".signature"}, signature, sig);
  endtask

  task automatic do_start(input int nv);
    start   = 1'b1;
    num_vec = CNT_W'(nv);
    step();
    start = 1'b0;
    m_dut.delete();
    m_ref.delete();
    m_nv  = nv;
    m_run = (nv != 0);
  endtask

  // Holds the beat until the checker takes it, with a bounded wait.
  task automatic send_beat(input logic [89:0] dv, input logic [89:0] rv);
    int   guard;
    logic got;
    guard        = 0;
    got          = 1'b0;
    bus.in_valid = 1'b1;
    bus.dut_y    = dv;
    bus.ref_y    = rv;
    while (!got && guard < 50) begin
      got = bus.in_ready;
      if (got) m_accept(dv, rv);
      step();
      guard++;
    end
    bus.in_valid = 1'b0;
    if (!got) begin
      n_tests++;
      n_fail++;
      $display("FAIL beat_timeout: got in_ready=0 for 50 cycles, expected 1");
    end
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, ".in_ready"}, bus.in_ready, 0);
    check({tag, ".busy"}, busy, 0);
    check({tag, ".done"}, done, 0);
    check({tag, ".pass"}, pass, 0);
    check({tag, ".err_cnt"}, err_cnt, 0);
    check({tag, ".first_err_idx"}, first_err_idx, 0);
    check({tag, ".first_err_fields"}, first_err_fields, 0);
    check({tag, ".signature"}, signature, 32'hFFFF_FFFF);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got no finish by %0t, expected finish", $time);
    $fatal(1);
  end

  initial begin
    tbl[0] = '{3, -1, 0, -1, 0, 16'd0, 16'd0, 18'h00000, 1'b1};
    tbl[1] = '{4, 2, 86, -1, 0, 16'd1, 16'd2, 18'h20000, 1'b0};
    tbl[2] = '{2, 0, 0, -1, 0, 16'd1, 16'd0, 18'h00001, 1'b0};
    tbl[3] = '{5, 4, 89, -1, 0, 16'd1, 16'd4, 18'h20000, 1'b0};
    tbl[4] = '{3, 1, 60, -1, 0, 16'd1, 16'd1, 18'h01000, 1'b0};
    tbl[5] = '{1, 0, 6, -1, 0, 16'd1, 16'd0, 18'h00002, 1'b0};
    tbl[6] = '{4, 1, 70, 3, 30, 16'd2, 16'd1, 18'h02000, 1'b0};

    rst          = 1'b1;
    start        = 1'b0;
    num_vec      = '0;
    bus.in_valid = 1'b0;
    bus.dut_y    = '0;
    bus.ref_y    = '0;
    m_nv         = 0;
    m_run        = 1'b0;
    #1;
    check_reset_vals("por");
    step();
    step();
    rst = 1'b0;
    step();

    // in_valid held in IDLE is ignored; start with num_vec=0 goes straight to done.
    bus.in_valid = 1'b1;
    bus.dut_y    = rand90();
    bus.ref_y    = ~bus.dut_y;
    for (int i = 0; i < 3; i++) begin
      check("idle.in_ready", bus.in_ready, 0);
      step();
    end
    check("idle.err_cnt", err_cnt, 0);
    check("idle.signature", signature, SEED);
    do_start(0);
    check("nv0.done", done, 1);
    check("nv0.pass", pass, 1);
    check("nv0.in_ready", bus.in_ready, 0);
    check("nv0.signature", signature, 32'hFFFF_FFFF);
    step();
    check("nv0.in_ready_later", bus.in_ready, 0);
    check("nv0.signature_later", signature, 32'hFFFF_FFFF);
    bus.in_valid = 1'b0;

    // Known-answer MISR vector.
    do_start(1);
    send_beat(90'h1, 90'h1);
    check("kat.signature", signature, 32'hFB3E_E248);
    check_stats("kat");

    // Table of single-run cases; each start also re-runs from DONE.
    for (int t = 0; t < 7; t++) begin
      do_start(tbl[t].nv);
      check($sformatf("tbl%0d.busy", t), busy, 1);
      for (int k = 0; k < tbl[t].nv; k++) begin
        r = rand90();
        d = r;
        if (k == tbl[t].fb1) d[tbl[t].bit1] = ~d[tbl[t].bit1];
        if (k == tbl[t].fb2) d[tbl[t].bit2] = ~d[tbl[t].bit2];
        if (k == tbl[t].nv - 1) check($sformatf("tbl%0d.done_before_last", t), done, 0);
        send_beat(d, r);
      end
      check($sformatf("tbl%0d.done", t), done, 1);
      check($sformatf("tbl%0d.err_cnt", t), err_cnt, tbl[t].e_err);
      check($sformatf("tbl%0d.first_err_idx", t), first_err_idx, tbl[t].e_idx);
      check($sformatf("tbl%0d.first_err_fields", t), first_err_fields, tbl[t].e_fields);
      check($sformatf("tbl%0d.pass", t), pass, tbl[t].e_pass);
      check_stats($sformatf("tbl%0d", t));
    end

    // Random gaps, random field errors, and an ignored start mid-run.
    for (int it = 0; it < 4; it++) begin
      do_start(5);
      acc_cnt = 0;
      for (int c = 0; c < 60; c++) begin
        v = (c > 40) ? 1'b1 : 1'($urandom_range(0, 1));
        d = rand90();
        r = d;
        if ($urandom_range(0, 2) == 0) r[$urandom_range(0, 89)] ^= 1'b1;
        bus.in_valid = v;
        bus.dut_y    = d;
        bus.ref_y    = r;
        if (c == 3) begin
          start   = 1'b1;
          num_vec = 16'd9;
        end
        check($sformatf("rnd%0d.in_ready", it), bus.in_ready, m_run);
        acc = v && bus.in_ready;
        if (acc) begin
          m_accept(d, r);
          acc_cnt++;
        end
        step();
        start = 1'b0;
      end
      bus.in_valid = 1'b0;
      check($sformatf("rnd%0d.accepted", it), acc_cnt, 5);
      check_stats($sformatf("rnd%0d", it));
    end

    // Asynchronous reset in the middle of a run with a recorded failure.
    do_start(4);
    d = rand90();
    send_beat(d, ~d);
    d = rand90();
    send_beat(d, d);
    check("midrst.err_cnt_before", err_cnt, 1);
    #2;
    rst = 1'b1;
    #1;
    check_reset_vals("midrst.async");
    @(posedge clk);
    #1;
    rst = 1'b0;
    m_run = 1'b0;
    step();
    check_reset_vals("midrst.after");

    // A normal run still works after the reset.
    do_start(2);
    send_beat(rand90(), rand90());
    d = rand90();
    send_beat(d, d);
    check_stats("postrst");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
